convergence_sequencer: RTL and testbench

Controller that drives the convergence check block through one convergence pass per k-means iteration. Per pass it requests the eight new centroids from the new-means calculation block in order 0..7, strobes the check block's per-centroid evaluation, samples the converged/not-converged verdict, and counts iterations against a limit. It sits between the top-level k-means controller, the new-means calculation block and the convergence check block.

---
 rtl/convergence_sequencer.sv | 135 +++++++++++++
 tb/tb_convergence_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/convergence_sequencer.sv
// Sequences one convergence pass per k-means iteration: fetches the eight new
// centroids in order, strobes the check block, samples its verdict and counts iterations.
module convergence_sequencer #(
  parameter int unsigned centroid_num = 8,
  parameter int unsigned iter_width   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kmeans_start,
  input  logic                  iter_start,
  input  logic [iter_width-1:0] max_iter,
  output logic                  mean_req,
  input  logic                  mean_valid,
  output logic [2:0]            cent_num,
  output logic                  convergence_reg_en,
  output logic                  convergence_regs_reset,
  input  logic                  has_converged,
  input  logic                  converge_res_available,
  output logic                  busy,
  output logic                  pass_done,
  output logic                  load_centroids,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout,
  output logic [iter_width-1:0] iter_count,
  output logic                  seq_error
);

  typedef enum logic [1:0] {IDLE, REQ, SAMPLE, FINISHED} state_t;

  state_t                state, state_next;
  logic [2:0]            idx;
  logic [iter_width-1:0] max_reg;
  logic [iter_width-1:0] count_next;
  logic                  last_cent;
  logic                  limit_hit;
  logic                  start_run;

  assign last_cent  = (idx == 3'(centroid_num - 1));
  assign count_next = (&iter_count) ? iter_count : iter_count + iter_width'(1);
  assign limit_hit  = (max_reg != '0) && (count_next == max_reg);
  assign start_run  = kmeans_start && ((state == IDLE) || (state == FINISHED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // cent_num is forced to 0 outside REQ so the check block never sees cent 7 twice.
  always_comb begin
    state_next             = state;
    mean_req               = 1'b0;
    cent_num               = '0;
    convergence_reg_en     = 1'b0;
    convergence_regs_reset = 1'b0;
    busy                   = 1'b0;
    case (state)
      IDLE: begin
        if (kmeans_start)    state_next = IDLE;
        else if (iter_start) state_next = REQ;
      end
      REQ: begin
        mean_req               = 1'b1;
        cent_num               = idx;
        convergence_reg_en     = mean_valid;
        convergence_regs_reset = 1'b1;
        busy                   = 1'b1;
        if (mean_valid && last_cent) state_next = SAMPLE;
      end
      SAMPLE: begin
        convergence_regs_reset = 1'b1;
        busy                   = 1'b1;
        if (has_converged || limit_hit) state_next = FINISHED;
        else                            state_next = IDLE;
      end
      FINISHED: begin
        if (kmeans_start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      max_reg        <= '0;
      iter_count     <= '0;
      pass_done      <= 1'b0;
      load_centroids <= 1'b0;
      done           <= 1'b0;
      converged      <= 1'b0;
      timeout        <= 1'b0;
      seq_error      <= 1'b0;
    end else begin
      pass_done      <= 1'b0;
      load_centroids <= 1'b0;
      if (start_run) begin
        iter_count <= '0;
        done       <= 1'b0;
        converged  <= 1'b0;
        timeout    <= 1'b0;
        seq_error  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iter_start) begin
              max_reg <= max_iter;
              idx     <= '0;
            end
          end
          REQ: begin
            if (mean_valid && !last_cent) idx <= idx + 3'd1;
          end
          SAMPLE: begin
            idx        <= '0;
            iter_count <= count_next;
            pass_done  <= 1'b1;
            if (!converge_res_available) seq_error <= 1'b1;
            if (has_converged) begin
              done      <= 1'b1;
              converged <= 1'b1;
            end else if (limit_hit) begin
              done    <= 1'b1;
              timeout <= 1'b1;
            end else begin
              load_centroids <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_convergence_sequencer.sv
// Directed bench for convergence_sequencer: a cycle table for one converging
// pass plus hand-written sequences for stall, timeout, reset and saturation.
module tb_convergence_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kmeans_start = 1'b0, iter_start = 1'b0, mean_valid = 1'b0;
  logic       has_converged = 1'b0, converge_res_available = 1'b0;
  logic [7:0] max_iter = '0;
  logic       mean_req, convergence_reg_en, convergence_regs_reset, busy;
  logic       pass_done, load_centroids, done, converged, timeout, seq_error;
  logic [2:0] cent_num;
  logic [7:0] iter_count;

  int vectors = 0;
  int miscompares = 0;

  convergence_sequencer #(.centroid_num(8), .iter_width(8)) dut (
    .clk(clk), .rst(rst), .kmeans_start(kmeans_start), .iter_start(iter_start),
    .max_iter(max_iter), .mean_req(mean_req), .mean_valid(mean_valid),
    .cent_num(cent_num), .convergence_reg_en(convergence_reg_en),
    .convergence_regs_reset(convergence_regs_reset), .has_converged(has_converged),
    .converge_res_available(converge_res_available), .busy(busy),
    .pass_done(pass_done), .load_centroids(load_centroids), .done(done),
    .converged(converged), .timeout(timeout), .iter_count(iter_count),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic kms; logic its; logic mv; logic hc; logic cra; logic [7:0] mi;
  } stim_t;

  typedef struct packed {
    logic req; logic [2:0] cent; logic en; logic rr; logic bsy; logic pd;
    logic ld; logic dn; logic cv; logic to; logic se; logic [7:0] cnt;
  } outs_t;

  typedef struct packed { stim_t stim; outs_t want; } vec_t;

  vec_t tbl [16];
  int   ntbl = 0;

  task automatic add(input bit kms, its, mv, hc, cra, input int mi,
                     input bit req, input int cent, input bit en, rr, bsy, pd,
                     input bit ld, dn, cv, to, se, input int cnt);
    tbl[ntbl].stim = '{kms, its, mv, hc, cra, 8'(mi)};
    tbl[ntbl].want = '{req, 3'(cent), en, rr, bsy, pd, ld, dn, cv, to, se, 8'(cnt)};
    ntbl++;
  endtask

  function automatic outs_t snap();
    outs_t o;
    o = '{mean_req, cent_num, convergence_reg_en, convergence_regs_reset, busy,
          pass_done, load_centroids, done, converged, timeout, seq_error, iter_count};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic kick();
    @(negedge clk); kmeans_start = 1'b1;
    @(negedge clk); kmeans_start = 1'b0;
  endtask

  // iter_start in cycle 0; reports the cycle pass_done is seen (-1 if never).
  task automatic do_pass(input bit hc, input bit cra, input int stall_at, input int stall_len,
                         input bit noise, output int pd_cycle, output int en_cnt,
                         output bit ld, output bit order_ok);
    int expect_cent;
    expect_cent = 0; pd_cycle = -1; en_cnt = 0; ld = 1'b0; order_ok = 1'b1;
    @(negedge clk);
    iter_start = 1'b1; mean_valid = 1'b0;
    has_converged = hc; converge_res_available = cra;
    for (int cyc = 1; cyc <= 40 && pd_cycle < 0; cyc++) begin
      @(negedge clk);
      iter_start   = noise && (cyc == 3);
      kmeans_start = noise && (cyc == 3);
      mean_valid   = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (convergence_reg_en) begin
        if (cent_num != 3'(expect_cent)) order_ok = 1'b0;
        expect_cent++;
        en_cnt++;
      end
      if (pass_done) begin
        pd_cycle = cyc;
        ld = load_centroids;
      end
    end
    iter_start = 1'b0; kmeans_start = 1'b0; mean_valid = 1'b0;
  endtask

  int pd, en;
  bit ld, ok;

  initial begin
    // reset held from time 0: every output at its reset value
    #2;
    check("reset_outputs", snap(), '0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check($sformatf("idle_after_reset_%0d", i), snap(), '0);
    end

    // converging pass, cycle by cycle
    add(1,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0,0,0, 0);
    add(0,1,0,0,0,0,  0,0,0,0,0, 0,0,0,0,0,0, 0);
    for (int k = 0; k < 8; k++)
      add(0,0,1,0,0,0, 1,k,1,1,1, 0,0,0,0,0,0, 0);
    add(0,0,0,1,1,0,  0,0,0,1,1, 0,0,0,0,0,0, 0);
    add(0,0,0,0,0,0,  0,0,0,0,0, 1,0,1,1,0,0, 1);
    add(0,1,0,0,0,0,  0,0,0,0,0, 0,0,1,1,0,0, 1);
    add(1,0,0,0,0,0,  0,0,0,0,0, 0,0,1,1,0,0, 1);
    add(0,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0,0,0, 0);
    add(0,0,1,0,0,0,  0,0,0,0,0, 0,0,0,0,0,0, 0);
    for (int i = 0; i < ntbl; i++) begin
      @(negedge clk);
      kmeans_start = tbl[i].stim.kms; iter_start = tbl[i].stim.its;
      mean_valid = tbl[i].stim.mv; has_converged = tbl[i].stim.hc;
      converge_res_available = tbl[i].stim.cra; max_iter = tbl[i].stim.mi;
      #1;
      check($sformatf("vec%0d", i), snap(), tbl[i].want);
    end
    kmeans_start = 1'b0; iter_start = 1'b0; mean_valid = 1'b0;

    // stall: mean_valid low 3 cycles while cent_num is 3
    kick();
    do_pass(1'b1, 1'b1, 4, 3, 1'b0, pd, en, ld, ok);
    check("stall_pass_done_cycle", pd, 13);
    check("stall_en_count", en, 8);
    check("stall_cent_order", ok, 1);
    check("stall_result", {done, converged, timeout, iter_count}, {3'b110, 8'd1});

    // timeout after three non-converging passes
    kick();
    max_iter = 8'd3;
    for (int p = 1; p <= 3; p++) begin
      do_pass(1'b0, 1'b1, 0, 0, 1'b0, pd, en, ld, ok);
      check($sformatf("to_pass%0d_pd", p), pd, 10);
      check($sformatf("to_pass%0d_load", p), ld, (p < 3) ? 1 : 0);
      check($sformatf("to_pass%0d_state", p), {done, converged, timeout, iter_count},
            (p < 3) ? {3'b000, 8'(p)} : {3'b101, 8'd3});
    end
    @(negedge clk); iter_start = 1'b1;
    @(negedge clk); iter_start = 1'b0; #1;
    check("done_ignores_iter_start", {busy, done, timeout}, 3'b011);

    // converged and limit reached together: converged wins
    kick();
    max_iter = 8'd1;
    do_pass(1'b1, 1'b1, 0, 0, 1'b0, pd, en, ld, ok);
    check("both_flags", {done, converged, timeout, ld}, 4'b1100);

    // seq_error and starts ignored while busy
    kick();
    max_iter = 8'd0;
    do_pass(1'b0, 1'b0, 0, 0, 1'b1, pd, en, ld, ok);
    check("noise_pd_cycle", pd, 10);
    check("noise_en_count", en, 8);
    check("seq_error_set", {seq_error, iter_count, ld, done}, {1'b1, 8'd1, 1'b1, 1'b0});
    kick(); #1;
    check("seq_error_cleared", {seq_error, iter_count}, 9'd0);

    // reset in the middle of a pass
    @(negedge clk); iter_start = 1'b1; mean_valid = 1'b1;
    @(negedge clk); iter_start = 1'b0;
    for (int i = 0; i < 20 && !(mean_req && cent_num == 3'd5); i++) @(negedge clk);
    #1;
    check("midpass_cent", cent_num, 5);
    #2 rst = 1'b1;
    #1 check("midpass_reset", snap(), '0);
    @(negedge clk); rst = 1'b0; mean_valid = 1'b0; #1;
    check("after_midpass_reset", snap(), '0);
    kick();
    do_pass(1'b1, 1'b1, 0, 0, 1'b0, pd, en, ld, ok);
    check("clean_pass", {pd[7:0], en[7:0], ok, done, converged, iter_count},
          {8'd10, 8'd8, 3'b111, 8'd1});

    // unlimited iterations: counter saturates at 255
    kick();
    max_iter = 8'd0;
    for (int p = 1; p <= 300; p++) begin
      do_pass(1'b0, 1'b1, 0, 0, 1'b0, pd, en, ld, ok);
      if (p == 254 || p == 255 || p == 300)
        check($sformatf("sat_pass%0d", p), {done, timeout, ld, iter_count},
              {3'b001, (p == 254) ? 8'd254 : 8'd255});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
